// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker
//
// Exhaustive response checker for 4-bit adders. On start it walks every
// operand pair (A outer, B inner, 256 vectors) out to the adder under test,
// holds each pair for SETTLE_CYCLES cycles, then compares the returned
// {carry, sum} against a 5-bit reference addition. It reports the mismatch
// count, the first failing pair and an overall pass flag.
//
// Parameters
//   SETTLE_CYCLES    cycles each operand pair is held before sampling (1..15)
//
// Ports
//   clk              clock, rising edge
//   rst_n            asynchronous active-low reset
//   start            begin a sweep (honoured in IDLE and DONE only)
//   a_out, b_out     registered operands driven to the adder under test
//   dut_sum          sum returned by the adder under test
//   dut_carry        carry-out returned by the adder under test
//   busy             sweep in progress (SETTLE or CHECK)
//   done             sweep complete, level until the next start or reset
//   pass             done with zero mismatches
//   err_count        mismatch count, 0..256
//   first_err_valid  at least one mismatch captured
//   first_err_a/b    operands of the first mismatch
//
// Build option
//   ADDER_CHECK_STOP_ON_ERR_EN  when defined, the first mismatch ends the
//                               sweep with operands frozen at that vector.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SETTLE | operands applied, counting down the settle time
// CHECK  | sampling and comparing the adder response for this vector
// DONE   | results held until start or reset

module adder_sweep_checker #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    input  logic [3:0] dut_sum,
    input  logic       dut_carry,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_count,
    output logic       first_err_valid,
    output logic [3:0] first_err_a,
    output logic [3:0] first_err_b
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state;
    logic [3:0] settle_cnt;

    // Reference is widened before the add so the carry is never truncated.
    logic [4:0] ref_sum;
    logic       mismatch;
    logic [8:0] err_next;
    logic [7:0] vec_next;

    always_comb begin
        ref_sum  = {1'b0, a_out} + {1'b0, b_out};
        mismatch = ({dut_carry, dut_sum} != ref_sum);
        err_next = err_count + {8'd0, mismatch};
        vec_next = {a_out, b_out} + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            settle_cnt      <= 4'd0;
            a_out           <= 4'd0;
            b_out           <= 4'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 9'd0;
            first_err_valid <= 1'b0;
            first_err_a     <= 4'd0;
            first_err_b     <= 4'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count       <= 9'd0;
                        first_err_valid <= 1'b0;
                        first_err_a     <= 4'd0;
                        first_err_b     <= 4'd0;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        a_out           <= 4'd0;
                        b_out           <= 4'd0;
                        settle_cnt      <= SETTLE_LOAD;
                        busy            <= 1'b1;
                        state           <= SETTLE;
                    end
                end

                SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    // <= guards against a zero load stalling the sweep forever.
                    if (settle_cnt <= 4'd1) begin
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_a     <= a_out;
                            first_err_b     <= b_out;
                        end
                    end
`ifdef ADDER_CHECK_STOP_ON_ERR_EN
                    if (mismatch) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                        state <= DONE;
                    end else if ({a_out, b_out} == 8'hFF) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 9'd0);
                        state <= DONE;
                    end else begin
                        {a_out, b_out} <= vec_next;
                        settle_cnt     <= SETTLE_LOAD;
                        state          <= SETTLE;
                    end
`else
                    if ({a_out, b_out} == 8'hFF) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // err_next folds in this last vector's result.
                        pass  <= (err_next == 9'd0);
                        state <= DONE;
                    end else begin
                        {a_out, b_out} <= vec_next;
                        settle_cnt     <= SETTLE_LOAD;
                        state          <= SETTLE;
                    end
`endif
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Bench for adder_sweep_checker. Three checker instances (SETTLE_CYCLES 1, 3
// and 2) each sit beside a small adder model whose fault mode is selectable:
//   0 ideal, 1 carry stuck at 0, 2 sum[0] stuck at 0,
//   3 result delayed by two register stages, 4 carry inverted.
// A table of sweep records is applied in a loop; each record is pushed to a
// scoreboard queue when its start is driven and popped when done rises.

module tb_adder_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v [3];
    int         mode_v  [3];

    logic [3:0] a_w     [3];
    logic [3:0] b_w     [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic       pass_w  [3];
    logic [8:0] err_w   [3];
    logic       fev_w   [3];
    logic [3:0] fa_w    [3];
    logic [3:0] fb_w    [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int SC = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        logic [4:0] q1, q2, ref5, ret;
        logic [3:0] a_l, b_l;
        logic       busy_l, done_l, pass_l, fev_l;
        logic [8:0] err_l;
        logic [3:0] fa_l, fb_l;

        always_ff @(posedge clk) begin
            q1 <= {1'b0, a_l} + {1'b0, b_l};
            q2 <= q1;
        end

        always_comb begin
            ref5 = {1'b0, a_l} + {1'b0, b_l};
            case (mode_v[g])
                1:       ret = {1'b0, ref5[3:0]};
                2:       ret = {ref5[4:1], 1'b0};
                3:       ret = q2;
                4:       ret = {~ref5[4], ref5[3:0]};
                default: ret = ref5;
            endcase
        end

        adder_sweep_checker #(.SETTLE_CYCLES(SC)) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .start           (start_v[g]),
            .a_out           (a_l),
            .b_out           (b_l),
            .dut_sum         (ret[3:0]),
            .dut_carry       (ret[4]),
            .busy            (busy_l),
            .done            (done_l),
            .pass            (pass_l),
            .err_count       (err_l),
            .first_err_valid (fev_l),
            .first_err_a     (fa_l),
            .first_err_b     (fb_l)
        );

        assign a_w[g]    = a_l;
        assign b_w[g]    = b_l;
        assign busy_w[g] = busy_l;
        assign done_w[g] = done_l;
        assign pass_w[g] = pass_l;
        assign err_w[g]  = err_l;
        assign fev_w[g]  = fev_l;
        assign fa_w[g]   = fa_l;
        assign fb_w[g]   = fb_l;
    end

    // -1 in a field means "not checked" for that record.
    typedef struct {
        int which;
        int mode;
        int pulse_at;
        int cycles;
        int errs;
        int pass;
        int fev;
        int fa;
        int fb;
        int final_ab;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag, input int w);
        check({tag, "_busy"}, int'(busy_w[w]), 0);
        check({tag, "_done"}, int'(done_w[w]), 0);
        check({tag, "_pass"}, int'(pass_w[w]), 0);
        check({tag, "_err"},  int'(err_w[w]),  0);
        check({tag, "_fev"},  int'(fev_w[w]),  0);
        check({tag, "_fab"},  int'({fa_w[w], fb_w[w]}), 0);
        check({tag, "_ab"},   int'({a_w[w], b_w[w]}),   0);
    endtask

    task automatic run_sweep(input vec_t v);
        int   cycles;
        logic [7:0] prev, cur;
        vec_t e;
        int   w;
        w = v.which;
        sb.push_back(v);
        @(negedge clk);
        mode_v[w]  = v.mode;
        start_v[w] = 1'b1;
        @(posedge clk);
        #1;
        start_v[w] = 1'b0;
        check("busy_rise",      int'(busy_w[w]), 1);
        check("done_drop",      int'(done_w[w]), 0);
        check("clear_on_start", int'(err_w[w]),  0);
        prev = {a_w[w], b_w[w]};
        check("first_vec", int'(prev), 0);
        cycles = 0;
        while (!done_w[w] && cycles < 4000) begin
            @(posedge clk);
            #1;
            cycles++;
            start_v[w] = (cycles == v.pulse_at);
            cur = {a_w[w], b_w[w]};
            if (cur != prev) begin
                check("vec_order", int'(cur), int'(prev + 8'd1));
                prev = cur;
            end
        end
        start_v[w] = 1'b0;
        check("done_seen", int'(done_w[w]), 1);
        e = sb.pop_front();
        if (e.cycles >= 0)   check("sweep_cycles", cycles, e.cycles);
        check("busy_fall", int'(busy_w[w]), 0);
        if (e.errs >= 0)     check("err_count", int'(err_w[w]), e.errs);
        else                 check("err_nonzero", int'(err_w[w] != 0), 1);
        check("pass", int'(pass_w[w]), e.pass);
        if (e.fev >= 0)      check("first_err_valid", int'(fev_w[w]), e.fev);
        if (e.fa >= 0)       check("first_err_a", int'(fa_w[w]), e.fa);
        if (e.fb >= 0)       check("first_err_b", int'(fb_w[w]), e.fb);
        if (e.final_ab >= 0) check("final_ab", int'({a_w[w], b_w[w]}), e.final_ab);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            mode_v[i]  = 0;
        end

`ifdef ADDER_CHECK_STOP_ON_ERR_EN
        tbl[0] = '{0, 0, -1,  512,   0, 1,  0,  0,  0, 255};
        tbl[1] = '{0, 1, -1,   64,   1, 0,  1,  1, 15, 8'h1F};
        tbl[2] = '{0, 2, -1,    4,   1, 0,  1,  0,  1, 8'h01};
        tbl[3] = '{0, 4, -1,    2,   1, 0,  1,  0,  0, 8'h00};
        tbl[4] = '{0, 3, -1,   -1,   1, 0,  1, -1, -1, -1};
`else
        tbl[0] = '{0, 0, -1,  512,   0, 1,  0,  0,  0, 255};
        tbl[1] = '{0, 1, -1,  512, 120, 0,  1,  1, 15, 255};
        tbl[2] = '{0, 2, -1,  512, 128, 0,  1,  0,  1, 255};
        tbl[3] = '{0, 4, -1,  512, 256, 0,  1,  0,  0, 255};
        tbl[4] = '{0, 3, -1,  512,  -1, 0,  1, -1, -1, 255};
`endif
        tbl[5] = '{2, 3, -1,  768,   0, 1,  0,  0,  0, 255};
        tbl[6] = '{1, 0, 100, 1024,  0, 1,  0,  0,  0, 255};
        tbl[7] = tbl[0];
        n = 7;

        #1;
        check_all_zero("reset", 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < n; i++) begin
            run_sweep(tbl[i]);
        end

        // Reset in the middle of a sweep, then a clean sweep afterwards.
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        check("mid_busy", int'(busy_w[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset", 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(tbl[7]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
